// File: rtl/gan_frame_streamer_pkg.sv
// Shared constants for the GAN frame streamer: frame layout, word indices, header fields, FSM states.
// FRAME_SEQ_EN adds a sequence/tag header word ahead of each frame.
package gan_frame_streamer_pkg;

  localparam int unsigned WORDS_PER_FRAME = 10;

  localparam int unsigned IDX_SCORE = 0;
  localparam int unsigned IDX_P1X1  = 1;
  localparam int unsigned IDX_P1X2  = 2;
  localparam int unsigned IDX_P1X3  = 3;
  localparam int unsigned IDX_P2X1  = 4;
  localparam int unsigned IDX_P2X2  = 5;
  localparam int unsigned IDX_P2X3  = 6;
  localparam int unsigned IDX_P3X1  = 7;
  localparam int unsigned IDX_P3X2  = 8;
  localparam int unsigned IDX_P3X3  = 9;

  localparam int unsigned SEQ_LSB = 0;
  localparam int unsigned SEQ_MSB = 15;
  localparam int unsigned TAG_BIT = 16;

`ifdef FRAME_SEQ_EN
  localparam int unsigned HDR_WORDS = 1;
`else
  localparam int unsigned HDR_WORDS = 0;
`endif

  localparam int unsigned NUM_WORDS = WORDS_PER_FRAME + HDR_WORDS;

  typedef enum logic [0:0] {StIdle, StSend} out_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Frame buffer: DEPTH entries of one captured GAN frame plus its tag bit, wrapping pointers.
module frame_fifo #(
  parameter int unsigned WIDTH = 321,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wrap_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= wrap_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/gan_frame_streamer.sv
// Issues samples into the GAN, captures results after PIPE_LAT, streams whole frames out.
// Define FRAME_SEQ_EN to prefix every frame with a sequence-number/tag header word.
module gan_frame_streamer
  import gan_frame_streamer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PIPE_LAT = 8,
  parameter int unsigned FRAMES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [WIDTH-1:0]                s_in_1,
  input  logic [WIDTH-1:0]                s_in_2,
  input  logic                            s_choice,
  output logic [WIDTH-1:0]                g_in_1,
  output logic [WIDTH-1:0]                g_in_2,
  output logic                            g_choice,
  input  logic [WORDS_PER_FRAME*WIDTH-1:0] r_frame,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [WIDTH-1:0]                m_data,
  output logic                            m_last,
  output logic                            m_tag
);

  localparam int unsigned FrameW = WORDS_PER_FRAME * WIDTH;
  localparam int unsigned CredW  = $clog2(FRAMES + 1);
  localparam int unsigned IdxW   = $clog2(NUM_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  logic [CredW-1:0]    credits_q, credits_d;
  logic                accept, issue_vld_q, capture, pop;
  logic [PIPE_LAT-1:0] tag_vld_q, tag_chc_q;
  logic [FrameW:0]     head;
  logic [CredW-1:0]    count;
  out_state_e          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d, word_sel;
  logic [WIDTH-1:0]    head_words [WORDS_PER_FRAME];
  logic                head_tag;

  assign s_ready  = (credits_q != '0);
  assign accept   = s_valid && s_ready;
  assign capture  = tag_vld_q[PIPE_LAT-1];
  assign head_tag = head[FrameW];
  assign word_sel = idx_q - IdxW'(HDR_WORDS);

  for (genvar w = 0; w < WORDS_PER_FRAME; w++) begin : g_words
    assign head_words[w] = head[w*WIDTH +: WIDTH];
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - CredW'(1);
    end else if (pop && !accept) begin
      credits_d = credits_q + CredW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q   <= CredW'(FRAMES);
      g_in_1      <= '0;
      g_in_2      <= '0;
      g_choice    <= 1'b0;
      issue_vld_q <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      g_in_1      <= accept ? s_in_1 : '0;
      g_in_2      <= accept ? s_in_2 : '0;
      g_choice    <= accept ? s_choice : 1'b0;
      issue_vld_q <= accept;
    end
  end

  // Tag pipe is fed from the registered issue stage, so its tap lines up with r_frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_chc_q <= '0;
    end else begin
      tag_vld_q[0] <= issue_vld_q;
      tag_chc_q[0] <= g_choice;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_chc_q[i] <= tag_chc_q[i-1];
      end
    end
  end

  frame_fifo #(
    .WIDTH (FrameW + 1),
    .DEPTH (FRAMES)
  ) u_frame_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .wdata ({tag_chc_q[PIPE_LAT-1], r_frame}),
    .rdata (head),
    .count (count)
  );

`ifdef FRAME_SEQ_EN
  localparam int unsigned SeqW = SEQ_MSB - SEQ_LSB + 1;
  logic [SeqW-1:0]  seq_q;
  logic [WIDTH-1:0] hdr_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q <= '0;
    end else if (pop) begin
      seq_q <= seq_q + SeqW'(1);
    end
  end

  always_comb begin
    hdr_word                  = '0;
    hdr_word[SEQ_MSB:SEQ_LSB] = seq_q;
    hdr_word[TAG_BIT]         = head_tag;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_tag   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count != '0) begin
          state_d = StSend;
          idx_d   = '0;
        end
      end
      StSend: begin
        m_valid = 1'b1;
        m_tag   = head_tag;
        m_last  = (idx_q == LastIdx);
`ifdef FRAME_SEQ_EN
        m_data  = (idx_q == '0) ? hdr_word : head_words[word_sel];
`else
        m_data  = head_words[word_sel];
`endif
        if (m_ready) begin
          if (m_last) begin
            pop   = 1'b1;
            idx_d = '0;
            // A frame captured on this same edge keeps the stream gapless.
            if (count <= CredW'(1) && !capture) begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_gan_frame_streamer.sv
// Randomised bench for gan_frame_streamer against a queue-based frame model; define
// FRAME_SEQ_EN here as for the RTL to cover header words.
module tb_gan_frame_streamer;

  localparam int W  = 32;
  localparam int PL = 8;
  localparam int FR = 2;
`ifdef FRAME_SEQ_EN
  localparam int NW = 11;
`else
  localparam int NW = 10;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid, s_ready, s_choice;
  logic [W-1:0]    s_in_1, s_in_2, g_in_1, g_in_2;
  logic            g_choice;
  logic [10*W-1:0] r_frame;
  logic            m_valid, m_ready, m_last, m_tag;
  logic [W-1:0]    m_data;

  initial forever #5 clk = ~clk;

  gan_frame_streamer #(
    .WIDTH    (W),
    .PIPE_LAT (PL),
    .FRAMES   (FR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_in_1   (s_in_1),
    .s_in_2   (s_in_2),
    .s_choice (s_choice),
    .g_in_1   (g_in_1),
    .g_in_2   (g_in_2),
    .g_choice (g_choice),
    .r_frame  (r_frame),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_tag    (m_tag)
  );

  typedef struct { logic [10*W-1:0] d; logic tag; } frm_t;
  typedef struct { int due; frm_t f; } pend_t;
  typedef struct { logic [W-1:0] d; logic last; logic tag; } obs_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic c; } hist_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Stand-in for the GAN: score and pixels are simple arithmetic of the latent inputs.
  function automatic logic [10*W-1:0] gan_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
    logic [10*W-1:0] r;
    r[W-1:0] = a + b + 32'h47 + {31'b0, c};
    for (int k = 1; k < 10; k++) r[k*W +: W] = W'(k) + (a ^ 32'h10) + (b + 32'd3);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_word(input frm_t f, input int idx, input logic [15:0] seq);
    int di;
    di = idx;
`ifdef FRAME_SEQ_EN
    if (idx == 0) return {15'b0, f.tag, seq};
    di = idx - 1;
`endif
    return f.d[di*W +: W];
  endfunction

  hist_t hist[$];
  initial begin
    r_frame = '0;
    forever begin
      @(posedge clk); #1;
      hist.push_back('{g_in_1, g_in_2, g_choice});
      if (hist.size() > PL) begin
        r_frame = gan_fn(hist[0].a, hist[0].b, hist[0].c);
        void'(hist.pop_front());
      end
    end
  end

  // Reference model: frames travel as whole objects through pending/buffer queues.
  int          md_credits = FR;
  frm_t        md_buf[$];
  pend_t       md_pend[$];
  bit          md_sending = 0;
  int          md_idx = 0;
  logic [15:0] md_seq = '0;
  int          md_edge = 0;
  int          md_acc_cnt = 0;
  logic [W-1:0] exp_g1 = '0, exp_g2 = '0;
  logic        exp_gc = 1'b0;

  initial forever begin
    bit acc, hs, lastw, was_ne;
    frm_t nf;
    @(posedge clk or negedge rst);
    if (!rst) begin
      md_credits = FR; md_buf.delete(); md_pend.delete();
      md_sending = 0; md_idx = 0; md_seq = '0;
      exp_g1 = '0; exp_g2 = '0; exp_gc = 1'b0;
    end else begin
      md_edge++;
      acc    = s_valid && (md_credits > 0);
      hs     = md_sending && m_ready;
      lastw  = hs && (md_idx == NW - 1);
      was_ne = (md_buf.size() != 0);
      if (acc) begin
        md_acc_cnt++;
        nf.d = gan_fn(s_in_1, s_in_2, s_choice);
        nf.tag = s_choice;
        md_pend.push_back('{md_edge + 1 + PL, nf});
      end
      exp_g1 = acc ? s_in_1 : '0;
      exp_g2 = acc ? s_in_2 : '0;
      exp_gc = acc ? s_choice : 1'b0;
      md_credits = md_credits - int'(acc) + int'(lastw);
      if (lastw) begin
        void'(md_buf.pop_front());
        md_seq++;
      end
      if (md_pend.size() != 0 && md_pend[0].due == md_edge) begin
        md_buf.push_back(md_pend[0].f);
        void'(md_pend.pop_front());
      end
      if (md_sending) begin
        if (hs) begin
          if (lastw) begin
            md_idx = 0;
            md_sending = (md_buf.size() != 0);
          end else begin
            md_idx++;
          end
        end
      end else if (was_ne) begin
        md_sending = 1;
        md_idx = 0;
      end
    end
  end

  obs_t         log_q[$];
  logic         prev_v = 1'b0, prev_r = 1'b0;
  logic [W-1:0] prev_d = '0;
  int           run = 0, max_run = 0;

  initial forever begin
    @(negedge clk);
    chk("s_ready", {31'b0, s_ready}, {31'b0, md_credits != 0});
    chk("m_valid", {31'b0, m_valid}, {31'b0, md_sending});
    chk("g_in_1", g_in_1, exp_g1);
    chk("g_in_2", g_in_2, exp_g2);
    chk("g_choice", {31'b0, g_choice}, {31'b0, exp_gc});
    if (md_sending && md_buf.size() != 0) begin
      chk("m_data", m_data, exp_word(md_buf[0], md_idx, md_seq));
      chk("m_last", {31'b0, m_last}, {31'b0, md_idx == NW - 1});
      chk("m_tag", {31'b0, m_tag}, {31'b0, md_buf[0].tag});
    end else begin
      chk("m_last_idle", {31'b0, m_last}, 32'd0);
    end
    if (rst && prev_v && !prev_r) chk("hold_m_data", m_data, prev_d);
    prev_v = rst && m_valid;
    prev_r = m_ready;
    prev_d = m_data;
    if (rst && m_valid && m_ready) log_q.push_back('{m_data, m_last, m_tag});
    run = m_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_in();
    s_in_1 = $urandom; s_in_2 = $urandom; s_choice = 1'($urandom_range(0, 1));
  endtask

  logic [W-1:0] lit [NW];
  bit found;
  int base;

  initial begin
    s_valid = 0; s_in_1 = '0; s_in_2 = '0; s_choice = 0; m_ready = 0;
    #2 rst = 0;
    #1;
    chk("rst_g_in_1", g_in_1, 32'd0);
    chk("rst_g_choice", {31'b0, g_choice}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", {31'b0, m_last}, 32'd0);
    chk("rst_m_tag", {31'b0, m_tag}, 32'd0);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd1);
    @(posedge clk); #1 rst = 1;

    // Single directed sample.
    m_ready = 1; step(2);
    s_valid = 1; s_in_1 = 32'h10; s_in_2 = 32'hFFFF_FFFD; s_choice = 1;
    step(1); s_valid = 0;
    chk("issue_g_in_1", g_in_1, 32'h10);
    chk("issue_g_in_2", g_in_2, 32'hFFFF_FFFD);
    chk("issue_g_choice", {31'b0, g_choice}, 32'd1);
    log_q.delete();
    step(1);
    chk("bubble_g_in_1", g_in_1, 32'd0);
    step(30);
`ifdef FRAME_SEQ_EN
    lit[0] = 32'h0001_0000;
    lit[1] = 32'h55;
    for (int i = 2; i < NW; i++) lit[i] = W'(i - 1);
`else
    lit[0] = 32'h55;
    for (int i = 1; i < NW; i++) lit[i] = W'(i);
`endif
    chk("single_count", W'(log_q.size()), W'(NW));
    if (log_q.size() == NW) begin
      for (int i = 0; i < NW; i++) begin
        chk("single_word", log_q[i].d, lit[i]);
        chk("single_last", {31'b0, log_q[i].last}, {31'b0, i == NW - 1});
        chk("single_tag", {31'b0, log_q[i].tag}, 32'd1);
      end
    end

    // Credit exhaustion with the output stalled.
    m_ready = 0; s_valid = 1;
    rand_in(); step(1);
    rand_in(); step(1);
    chk("credit_empty_s_ready", {31'b0, s_ready}, 32'd0);
    rand_in(); step(3);
    s_valid = 0;
    step(15);
    m_ready = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_valid && m_last) found = 1;
    end
    if (found) begin
      step(1);
      chk("credit_return_s_ready", {31'b0, s_ready}, 32'd1);
    end else begin
      chk("drain_timeout", 32'd0, 32'd1);
    end
    step(20);

    // Backpressure pattern 1,0,0,1.
    for (int c = 0; c < 80; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      s_valid = ($urandom_range(0, 2) == 0);
      rand_in();
      step(1);
    end
    s_valid = 0; m_ready = 1; step(40);

    // Back-to-back frames.
    s_valid = 1; rand_in(); step(1); rand_in(); step(1); s_valid = 0;
    max_run = 0;
    step(40);
    chk("b2b_run", W'(max_run), W'(2 * NW));

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 9) < 7);
      rand_in();
      step(1);
    end
    s_valid = 0; m_ready = 1; step(40);

    // Reset in the middle of a frame.
    s_valid = 1; rand_in(); step(1); s_valid = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (md_sending && md_idx == 4) found = 1;
    end
    chk("reach_idx4", {31'b0, found}, 32'd1);
    rst = 0; #1;
    chk("midrst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd1);
    step(1); rst = 1;
    s_valid = 1; s_in_1 = 32'h10; s_in_2 = 32'hFFFF_FFFD; s_choice = 0;
    step(1); s_valid = 0;
    log_q.delete();
    step(30);
    chk("postrst_count", W'(log_q.size()), W'(NW));
`ifdef FRAME_SEQ_EN
    chk("postrst_first", log_q[0].d, 32'h0);
`else
    chk("postrst_first", log_q[0].d, 32'h54);
`endif

    // Three frames after a fresh reset.
    rst = 0; step(1); rst = 1;
    log_q.delete();
    base = md_acc_cnt;
    s_valid = 1;
    for (int i = 0; i < 100 && md_acc_cnt < base + 3; i++) begin
      rand_in(); step(1);
    end
    s_valid = 0;
    step(60);
    chk("three_count", W'(log_q.size()), W'(3 * NW));
    if (log_q.size() == 3 * NW) begin
      for (int f = 0; f < 3; f++) begin
        chk("three_last", {31'b0, log_q[f*NW + NW - 1].last}, 32'd1);
        chk("three_not_last", {31'b0, log_q[f*NW + NW - 2].last}, 32'd0);
`ifdef FRAME_SEQ_EN
        chk("three_seq", {16'b0, log_q[f*NW].d[15:0]}, W'(f));
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
